wb_queue: RTL and testbench



---
 rtl/wb_queue_pkg.sv | 18 +
 rtl/wb_queue_fifo.sv | 67 ++++++
 rtl/wb_queue.sv | 108 ++++++++++
 tb/tb_wb_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wb_queue_pkg.sv
// Shared types and helpers for the write-back queue (package wbq_pkg).
package wbq_pkg;

    localparam int REG_W      = 5;
    localparam int DATA_W_DEF = 32;

    // Entry layout at the default result width; wider builds declare the same layout locally.
    typedef struct packed {
        logic [REG_W-1:0]      rd;
        logic [DATA_W_DEF-1:0] data;
    } wbq_entry_t;

    // Slots available this cycle: free entries plus the one released by the unconditional drain.
    function automatic int unsigned wbq_space(input int unsigned depth, input int unsigned cnt);
        return depth - cnt + ((cnt != 0) ? 32'd1 : 32'd0);
    endfunction

endpackage

// File: rtl/wb_queue_fifo.sv
// Circular entry store for wb_queue: up to two in-order pushes and one pop per cycle.
// With WBQ_BYPASS_EN defined the full array and head pointer are exported for lookup.
module wbq_fifo
    import wbq_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wbq_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0,
    input  entry_t           din0,
    input  logic             push1,
    input  entry_t           din1,
    input  logic             pop,
    output entry_t           head_entry,
`ifdef WBQ_BYPASS_EN
    output entry_t           entries_o [DEPTH],
    output logic [PTR_W-1:0] head_ptr,
`endif
    output logic [CNT_W-1:0] count
);

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail_nxt;
    logic [CNT_W-1:0] count_q, count_d;

    // push1 is only ever raised together with push0, so it lands one slot behind it.
    always_comb begin
        entries_d = entries_q;
        tail_nxt  = tail_q + PTR_W'(1);
        if (push0) entries_d[tail_q]   = din0;
        if (push1) entries_d[tail_nxt] = din1;
        tail_d  = tail_q + PTR_W'(push0) + PTR_W'(push1);
        head_d  = head_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

    assign head_entry = entries_q[head_q];
    assign count      = count_q;
`ifdef WBQ_BYPASS_EN
    assign entries_o  = entries_q;
    assign head_ptr   = head_q;
`endif

endmodule

// File: rtl/wb_queue.sv
// Write-back queue merging ALU and MDU results in order onto the register file write port.
// Define WBQ_BYPASS_EN to build the pending-entry lookup; otherwise lookuphit/lookupdata read 0.
module wb_queue
    import wbq_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aluvalid,
    output logic              aluready,
    input  logic [REG_W-1:0]  alureg,
    input  logic [DATA_W-1:0] aludata,
    input  logic              mduvalid,
    output logic              mduready,
    input  logic [REG_W-1:0]  mdureg,
    input  logic [DATA_W-1:0] mdudata,
    output logic              rw,
    output logic [REG_W-1:0]  writereg,
    output logic [DATA_W-1:0] datawritten,
    input  logic [REG_W-1:0]  lookupreg,
    output logic              lookuphit,
    output logic [DATA_W-1:0] lookupdata,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    int unsigned space;
    logic        alu_keep, mdu_keep;
    logic        push0, push1, pop;
    entry_t      din0, din1, head_entry;

`ifdef WBQ_BYPASS_EN
    entry_t           fifo_entries [DEPTH];
    logic [PTR_W-1:0] head_ptr;
`endif

    // Readiness depends only on registered occupancy (and aluvalid for the shared last slot).
    assign space    = wbq_space(DEPTH, 32'(count));
    assign aluready = (space >= 1);
    assign mduready = (space >= 2) | ((space == 1) & ~aluvalid);

    // Writes to r0 complete the handshake but are dropped before reaching storage.
    assign alu_keep = aluvalid & aluready & (alureg != '0);
    assign mdu_keep = mduvalid & mduready & (mdureg != '0);

    always_comb begin
        push0 = alu_keep | mdu_keep;
        push1 = alu_keep & mdu_keep;
        din0  = alu_keep ? entry_t'{rd: alureg, data: aludata} : entry_t'{rd: mdureg, data: mdudata};
        din1  = entry_t'{rd: mdureg, data: mdudata};
    end

    assign pop = (count != '0);

    wbq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push0      (push0),
        .din0       (din0),
        .push1      (push1),
        .din1       (din1),
        .pop        (pop),
        .head_entry (head_entry),
`ifdef WBQ_BYPASS_EN
        .entries_o  (fifo_entries),
        .head_ptr   (head_ptr),
`endif
        .count      (count)
    );

    // Head is presented whenever occupied; outputs move only on posedge or async reset.
    assign rw          = pop;
    assign writereg    = pop ? head_entry.rd   : '0;
    assign datawritten = pop ? head_entry.data : '0;

`ifdef WBQ_BYPASS_EN
    // Walk oldest to youngest so the last match taken is the youngest pending write.
    always_comb begin
        lookuphit  = 1'b0;
        lookupdata = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (lookupreg != '0) &&
                (fifo_entries[head_ptr + PTR_W'(k)].rd == lookupreg)) begin
                lookuphit  = 1'b1;
                lookupdata = fifo_entries[head_ptr + PTR_W'(k)].data;
            end
        end
    end
`else
    logic unused_lookupreg;
    assign unused_lookupreg = ^lookupreg;
    assign lookuphit        = 1'b0;
    assign lookupdata       = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Randomized scoreboard bench for wb_queue against an in-order queue model.
module tb_wb_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              aluvalid, mduvalid;
    logic              aluready, mduready;
    logic [4:0]        alureg, mdureg, lookupreg;
    logic [DATA_W-1:0] aludata, mdudata;
    logic              rw, lookuphit;
    logic [4:0]        writereg;
    logic [DATA_W-1:0] datawritten, lookupdata;
    logic [CNT_W-1:0]  count;

    wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .aluvalid    (aluvalid),
        .aluready    (aluready),
        .alureg      (alureg),
        .aludata     (aludata),
        .mduvalid    (mduvalid),
        .mduready    (mduready),
        .mdureg      (mdureg),
        .mdudata     (mdudata),
        .rw          (rw),
        .writereg    (writereg),
        .datawritten (datawritten),
        .lookupreg   (lookupreg),
        .lookuphit   (lookuphit),
        .lookupdata  (lookupdata),
        .count       (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_q [$];
    exp_t pend  [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus: commit last cycle's accepted entries, then offer new inputs.
    task automatic cycle(input logic av, input logic [4:0] ar, input logic [DATA_W-1:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [DATA_W-1:0] md,
                         input logic [4:0] lk);
        int                occ;
        int                space;
        logic              eal, eml, ehit;
        logic [DATA_W-1:0] edat;
        @(posedge clk);
        #1;
        while (pend.size() > 0) exp_q.push_back(pend.pop_front());
        occ = exp_q.size();
        chk("count", 64'(count), 64'(occ));
        space = DEPTH - occ + ((occ != 0) ? 1 : 0);
        eal   = (space >= 1);
        eml   = (space >= 2) || ((space == 1) && !av);
        aluvalid = av; alureg = ar; aludata = ad;
        mduvalid = mv; mdureg = mr; mdudata = md;
        lookupreg = lk;
        #1;
        chk("aluready", 64'(aluready), 64'(eal));
        chk("mduready", 64'(mduready), 64'(eml));
        ehit = 1'b0;
        edat = '0;
`ifdef WBQ_BYPASS_EN
        if (lk != 0) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].rd == lk) begin
                    ehit = 1'b1;
                    edat = exp_q[i].data;
                end
            end
        end
`endif
        chk("lookuphit", 64'(lookuphit), 64'(ehit));
        chk("lookupdata", 64'(lookupdata), 64'(edat));
        if (av && eal && ar != 0) pend.push_back('{ar, ad});
        if (mv && eml && mr != 0) pend.push_back('{mr, md});
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
    endtask

    // Write port observed at the negedge where the register file commits.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rw", 64'(rw), 64'd1);
                    chk("writereg", 64'(writereg), 64'(mon_e.rd));
                    chk("datawritten", 64'(datawritten), 64'(mon_e.data));
                end else begin
                    chk("rw_idle", 64'(rw), 64'd0);
                    chk("writereg_idle", 64'(writereg), 64'd0);
                    chk("datawritten_idle", 64'(datawritten), 64'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        aluvalid = 1'b0; alureg = '0; aludata = '0;
        mduvalid = 1'b0; mdureg = '0; mdudata = '0;
        lookupreg = '0;
        #3;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_rw", 64'(rw), 64'd0);
        chk("reset_writereg", 64'(writereg), 64'd0);
        chk("reset_datawritten", 64'(datawritten), 64'd0);
        chk("reset_aluready", 64'(aluready), 64'd1);
        chk("reset_mduready", 64'(mduready), 64'd1);
        chk("reset_lookuphit", 64'(lookuphit), 64'd0);
        chk("reset_lookupdata", 64'(lookupdata), 64'd0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single ALU write, then ALU+MDU same cycle
        cycle(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, '0, 5'd0);
        repeat (2) idle();
        cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd0);
        repeat (3) idle();

        // Continuous ALU stream
        repeat (6) cycle(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0, 5'd0, '0, 5'd0);
        repeat (2) idle();

        // Fill with dual pushes, then keep both producers offering at full
        repeat (3) cycle(1'b1, 5'($urandom_range(1, 31)), $urandom,
                         1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0);
        repeat (4) cycle(1'b1, 5'($urandom_range(1, 31)), $urandom,
                         1'b1, 5'($urandom_range(1, 31)), $urandom, 5'd0);
        repeat (6) idle();

        // r0 destinations are accepted and dropped
        cycle(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, '0, 5'd0);
        cycle(1'b1, 5'd0, 32'h1234, 1'b1, 5'd9, 32'h99, 5'd0);
        cycle(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h55, 5'd0);
        repeat (2) idle();

        // Two pending writes to r7, probe, then reset while draining
        cycle(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 5'd7);
        cycle(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd7);
        #1;
        rst = 1'b1;
        exp_q.delete();
        pend.delete();
        #1;
        chk("midrst_rw", 64'(rw), 64'd0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_writereg", 64'(writereg), 64'd0);
        chk("midrst_lookuphit", 64'(lookuphit), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        repeat (400) begin
            cycle(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
        end
        repeat (DEPTH + 2) idle();
        @(negedge clk);
        #1;
        chk("final_count", 64'(count), 64'd0);
        chk("final_rw", 64'(rw), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
